fir_out_buffer: RTL and testbench
=================================

Name: fir_out_buffer

Overview:
- Output elastic buffer directly downstream of the FIR filter top level.
- Captures each 16-bit filtered sample presented with its valid strobe and stores it in a small circular FIFO.
- Presents samples to the consumer with a valid/ready handshake.
- Reports occupancy, a sticky overflow flag and a saturating drop counter, so backpressure from the consumer never stalls the filter.

Parameters:
- DATA_W, 16, sample width; matches the filter output word.
- DEPTH, 16, number of FIFO entries; must be a power of 2 and at least 2.
- AW, 4, address width; equals log2(DEPTH).
- DROP_W, 8, width of the saturating dropped-sample counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_W  sample from the filter.
- valid_in  input  1  din is valid this cycle (one-cycle strobe per sample).
- flush  input  1  synchronous clear of FIFO contents.
- clr_ovf  input  1  synchronous clear of overflow and drop_cnt.
- dout  output  DATA_W  head-of-FIFO sample; 0 when empty.
- valid_out  output  1  FIFO non-empty; dout is valid.
- ready_in  input  1  consumer accepts dout this cycle.
- count  output  AW+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: at least one sample was dropped.
- drop_cnt  output  DROP_W  number of dropped samples, saturating at all-ones.

Behaviour:
- Reset (asynchronous, active-high):
  - wr_ptr, rd_ptr and count go to 0.
  - overflow and drop_cnt go to 0.
  - Memory contents are don't-care; dout reads 0 because the FIFO is empty.
- Events evaluated each rising edge:
  - push = valid_in.
  - pop = valid_out & ready_in.
- Priority order: flush, then push/pop.
- flush = 1:
  - wr_ptr, rd_ptr and count go to 0.
  - Any push or pop in the same cycle is ignored; an ignored push does NOT count as a drop.
- Pop: rd_ptr advances by 1, modulo DEPTH.
- Push when not full: mem[wr_ptr] <= din and wr_ptr advances by 1, modulo DEPTH.
- Push when full and pop in the same cycle:
  - The write is accepted, since a slot frees that edge.
  - count is unchanged.
- Push when full and no pop:
  - The sample is dropped and no pointer moves.
  - overflow <= 1.
  - drop_cnt increments unless it is already all-ones.
- count update:
  - +1 on an accepted push without pop.
  - -1 on a pop without push.
  - Unchanged on both or neither.
- Pop is only possible when count > 0. Simultaneous push and pop with count == 0 cannot occur, because valid_out is 0.
- Pointer wrap-around: pointers are AW bits and wrap naturally; full/empty are derived from count, not from pointer comparison.
- Output path:
  - valid_out = (count != 0).
  - dout = mem[rd_ptr] when valid_out, else 0.
  - Latency: a sample pushed at edge N is visible on dout/valid_out after edge N if the FIFO was empty (first-word fall-through, 1-cycle latency).
- Handshake rules:
  - dout stays stable while valid_out = 1 and ready_in = 0.
  - ready_in is ignored while valid_out = 0.
- clr_ovf = 1:
  - overflow <= 0 and drop_cnt <= 0.
  - If a drop occurs in the same cycle, the drop wins: overflow = 1 and drop_cnt = 1.
- Reset asserted mid-transfer: all state clears immediately; no partial sample is emitted afterwards.
- Synthesisable memory:
  - Register array with synchronous write.
  - Asynchronous read at rd_ptr.

Test Plan:
- Fill and drain: 5 pushes of 0x0101..0x0505 with ready_in = 0; count = 5. Then set ready_in = 1; dout sequence is 0x0101..0x0505 on consecutive cycles, then valid_out = 0, dout = 0, count = 0.
- Overflow: ready_in = 0; 18 pushes of 0x1000+i. Required: full = 1, count = 16, overflow = 1, drop_cnt = 2. Draining yields 0x1000..0x100F, and 0x1010/0x1011 are absent.
- Full with simultaneous push and pop: at count = 16, push 0xBEEF with ready_in = 1. Required: no drop, count stays 16, 0xBEEF emerges as the 16th sample after the current head.
- Wrap-around: 40 samples streamed with ready_in toggling 1/0 every cycle and pushes every 3rd cycle. Output sequence equals input sequence with no loss, and count never exceeds 2.
- Flush and clear interactions:
  - Flush with count = 7 and a push in the same cycle: count = 0, valid_out = 0, drop_cnt unchanged.
  - Then clr_ovf coinciding with a drop at full: overflow = 1, drop_cnt = 1.
- Async reset and saturation:
  - With DROP_W = 8, 300 drops give drop_cnt = 255.
  - Asserting reset between edges with count = 9 clears count, overflow, drop_cnt and valid_out without waiting for a clock edge.

Source files
------------

// File: rtl/fir_out_buffer_if.sv
// Purpose : handshake/bus bundle between the FIR output buffer and its neighbours.
// Latency : n/a (wiring only).
// Backpressure: carries ready_in from the consumer; the filter side has no ready.
//
// Ports:
//   din/valid_in        sample and strobe from the filter
//   flush/clr_ovf       synchronous control strobes
//   dout/valid_out      head-of-FIFO sample towards the consumer
//   ready_in            consumer accept
//   count/full          occupancy status
//   overflow/drop_cnt   sticky drop flag and saturating drop counter
interface fir_out_buffer_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 4,
    parameter int DROP_W = 8
);
    logic [DATA_W-1:0] din;
    logic              valid_in;
    logic              flush;
    logic              clr_ovf;
    logic              ready_in;
    logic [DATA_W-1:0] dout;
    logic              valid_out;
    logic [AW:0]       count;
    logic              full;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    // Buffer side
    modport slave (
        input  din, valid_in, flush, clr_ovf, ready_in,
        output dout, valid_out, count, full, overflow, drop_cnt
    );

    // Filter/consumer side
    modport master (
        output din, valid_in, flush, clr_ovf, ready_in,
        input  dout, valid_out, count, full, overflow, drop_cnt
    );
endinterface

// File: rtl/fir_out_buffer.sv
// Purpose : elastic output FIFO after the FIR filter; drops samples when full instead of stalling.
// Latency : first-word fall-through, a sample pushed at edge N is on dout after edge N.
// Backpressure: ready_in holds dout stable; the filter is never stalled, overflow drops are counted.
//
// Ports:
//   clk    rising-edge clock for all state
//   reset  asynchronous active-high reset
//   bus    fir_out_buffer_if.slave (din/valid_in in, dout/valid_out out, ready_in,
//          flush, clr_ovf, count, full, overflow, drop_cnt)
module fir_out_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int DROP_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    fir_out_buffer_if.slave bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q,  count_d;
    logic              ovf_q,    ovf_d;
    logic [DROP_W-1:0] drop_q,   drop_d;

    logic full;
    logic not_empty;
    logic push;
    logic pop;
    logic wr_en;
    logic drop;

    // Full/empty come from the occupancy counter, so pointers can simply wrap.
    assign full      = (count_q == FULL_CNT);
    assign not_empty = (count_q != '0);
    assign push      = bus.valid_in;
    assign pop       = not_empty & bus.ready_in;

    // A push at full is still accepted if the head leaves on the same edge.
    // Flush swallows any push without treating it as a drop.
    assign wr_en = push & ~bus.flush & (~full | pop);
    assign drop  = push & ~bus.flush & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // A drop on the same edge as clr_ovf restarts the statistics at one.
        if (drop) begin
            ovf_d = 1'b1;
            if (bus.clr_ovf) begin
                drop_d = DROP_W'(1);
            end else if (!(&drop_q)) begin
                drop_d = drop_q + 1'b1;
            end
        end else if (bus.clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Storage carries no reset; its contents are only visible through count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.dout      = not_empty ? mem_q[rd_ptr_q] : '0;
    assign bus.valid_out = not_empty;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.overflow  = ovf_q;
    assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_fir_out_buffer.sv
module tb_fir_out_buffer;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    fir_out_buffer_if #(.DATA_W(16), .AW(4), .DROP_W(8)) bus ();

    fir_out_buffer #(.DATA_W(16), .DEPTH(16), .AW(4), .DROP_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        vectors++;
        if (bus.count !== 5'd0) begin
            miscompares++; $display("FAIL reset_count: got %0d expected 0", bus.count);
        end
        vectors++;
        if (bus.valid_out !== 1'b0 || bus.dout !== 16'h0000) begin
            miscompares++; $display("FAIL reset_out: got v=%b d=%h expected v=0 d=0000", bus.valid_out, bus.dout);
        end
        vectors++;
        if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0 || bus.full !== 1'b0) begin
            miscompares++; $display("FAIL reset_status: got ovf=%b drop=%0d full=%b expected 0/0/0",
                                    bus.overflow, bus.drop_cnt, bus.full);
        end
    endtask

    task automatic test_fill_drain;
        bus.ready_in = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus.valid_in = 1'b1;
            bus.din      = {i[7:0], i[7:0]};
            tick();
        end
        bus.valid_in = 1'b0;
        vectors++;
        if (bus.count !== 5'd5) begin
            miscompares++; $display("FAIL fill_count: got %0d expected 5", bus.count);
        end
        bus.ready_in = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            vectors++;
            if (bus.valid_out !== 1'b1 || bus.dout !== {k[7:0], k[7:0]}) begin
                miscompares++; $display("FAIL drain_%0d: got v=%b d=%h expected v=1 d=%h",
                                        k, bus.valid_out, bus.dout, {k[7:0], k[7:0]});
            end
            tick();
        end
        bus.ready_in = 1'b0;
        vectors++;
        if (bus.valid_out !== 1'b0 || bus.dout !== 16'h0000 || bus.count !== 5'd0) begin
            miscompares++; $display("FAIL drain_empty: got v=%b d=%h c=%0d expected 0/0000/0",
                                    bus.valid_out, bus.dout, bus.count);
        end
    endtask

    task automatic test_overflow;
        bus.ready_in = 1'b0;
        for (int i = 0; i < 18; i++) begin
            bus.valid_in = 1'b1;
            bus.din      = 16'h1000 + 16'(i);
            tick();
        end
        bus.valid_in = 1'b0;
        vectors++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
            miscompares++; $display("FAIL ovf_full: got full=%b c=%0d expected 1/16", bus.full, bus.count);
        end
        vectors++;
        if (bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd2) begin
            miscompares++; $display("FAIL ovf_drops: got ovf=%b drop=%0d expected 1/2", bus.overflow, bus.drop_cnt);
        end
    endtask

    task automatic test_full_push_pop;
        vectors++;
        if (bus.dout !== 16'h1000) begin
            miscompares++; $display("FAIL fpp_head: got %h expected 1000", bus.dout);
        end
        bus.valid_in = 1'b1;
        bus.din      = 16'hBEEF;
        bus.ready_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        vectors++;
        if (bus.count !== 5'd16 || bus.drop_cnt !== 8'd2) begin
            miscompares++; $display("FAIL fpp_count: got c=%0d drop=%0d expected 16/2", bus.count, bus.drop_cnt);
        end
        for (int k = 1; k < 16; k++) begin
            vectors++;
            if (bus.dout !== 16'h1000 + 16'(k)) begin
                miscompares++; $display("FAIL fpp_drain_%0d: got %h expected %h", k, bus.dout, 16'h1000 + 16'(k));
            end
            tick();
        end
        vectors++;
        if (bus.valid_out !== 1'b1 || bus.dout !== 16'hBEEF) begin
            miscompares++; $display("FAIL fpp_beef: got v=%b d=%h expected 1/beef", bus.valid_out, bus.dout);
        end
        tick();
        bus.ready_in = 1'b0;
        vectors++;
        if (bus.valid_out !== 1'b0 || bus.count !== 5'd0) begin
            miscompares++; $display("FAIL fpp_empty: got v=%b c=%0d expected 0/0", bus.valid_out, bus.count);
        end
    endtask

    task automatic test_wrap;
        logic [15:0] q[$];
        int sent;
        int recv;
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 400 && (sent < 40 || q.size() != 0); cyc++) begin
            bus.ready_in = cyc[0];
            bus.valid_in = (cyc % 3 == 0) && (sent < 40);
            bus.din      = 16'h2000 + 16'(sent);
            vectors++;
            if (bus.valid_out !== (q.size() != 0)) begin
                miscompares++; $display("FAIL wrap_valid cyc%0d: got %b expected %b", cyc, bus.valid_out, q.size() != 0);
            end
            vectors++;
            if (bus.count > 5'd2) begin
                miscompares++; $display("FAIL wrap_count cyc%0d: got %0d expected <=2", cyc, bus.count);
            end
            if (bus.ready_in && q.size() != 0) begin
                vectors++;
                if (bus.dout !== q[0]) begin
                    miscompares++; $display("FAIL wrap_data cyc%0d: got %h expected %h", cyc, bus.dout, q[0]);
                end
                void'(q.pop_front());
                recv++;
            end
            if (bus.valid_in) begin
                q.push_back(bus.din);
                sent++;
            end
            tick();
        end
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
        vectors++;
        if (recv !== 40 || bus.valid_out !== 1'b0) begin
            miscompares++; $display("FAIL wrap_total: got recv=%0d v=%b expected 40/0", recv, bus.valid_out);
        end
    endtask

    task automatic test_flush_clr;
        bus.ready_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.valid_in = 1'b1;
            bus.din      = 16'h3000 + 16'(i);
            tick();
        end
        vectors++;
        if (bus.count !== 5'd7) begin
            miscompares++; $display("FAIL flush_pre: got %0d expected 7", bus.count);
        end
        bus.din   = 16'h3333;
        bus.flush = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.valid_in = 1'b0;
        vectors++;
        if (bus.count !== 5'd0 || bus.valid_out !== 1'b0 || bus.dout !== 16'h0000) begin
            miscompares++; $display("FAIL flush_state: got c=%0d v=%b d=%h expected 0/0/0000",
                                    bus.count, bus.valid_out, bus.dout);
        end
        vectors++;
        if (bus.drop_cnt !== 8'd2 || bus.overflow !== 1'b1) begin
            miscompares++; $display("FAIL flush_drops: got drop=%0d ovf=%b expected 2/1", bus.drop_cnt, bus.overflow);
        end
        for (int i = 0; i < 16; i++) begin
            bus.valid_in = 1'b1;
            bus.din      = 16'h4000 + 16'(i);
            tick();
        end
        bus.din     = 16'h4444;
        bus.clr_ovf = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        bus.clr_ovf  = 1'b0;
        vectors++;
        if (bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd1) begin
            miscompares++; $display("FAIL clr_drop: got ovf=%b drop=%0d expected 1/1", bus.overflow, bus.drop_cnt);
        end
        vectors++;
        if (bus.count !== 5'd16 || bus.dout !== 16'h4000) begin
            miscompares++; $display("FAIL clr_fifo: got c=%0d d=%h expected 16/4000", bus.count, bus.dout);
        end
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        vectors++;
        if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
            miscompares++; $display("FAIL clr_only: got ovf=%b drop=%0d expected 0/0", bus.overflow, bus.drop_cnt);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic test_sat_async_reset;
        bus.ready_in = 1'b0;
        for (int i = 0; i < 316; i++) begin
            bus.valid_in = 1'b1;
            bus.din      = 16'h5000 + 16'(i);
            tick();
        end
        bus.valid_in = 1'b0;
        vectors++;
        if (bus.drop_cnt !== 8'd255 || bus.overflow !== 1'b1) begin
            miscompares++; $display("FAIL sat_cnt: got drop=%0d ovf=%b expected 255/1", bus.drop_cnt, bus.overflow);
        end
        bus.ready_in = 1'b1;
        repeat (7) tick();
        bus.ready_in = 1'b0;
        vectors++;
        if (bus.count !== 5'd9 || bus.dout !== 16'h5007) begin
            miscompares++; $display("FAIL sat_pre_reset: got c=%0d d=%h expected 9/5007", bus.count, bus.dout);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.count !== 5'd0 || bus.valid_out !== 1'b0 || bus.dout !== 16'h0000) begin
            miscompares++; $display("FAIL async_fifo: got c=%0d v=%b d=%h expected 0/0/0000",
                                    bus.count, bus.valid_out, bus.dout);
        end
        vectors++;
        if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
            miscompares++; $display("FAIL async_status: got ovf=%b drop=%0d expected 0/0", bus.overflow, bus.drop_cnt);
        end
        #1;
        reset = 1'b0;
        bus.ready_in = 1'b1;
        tick();
        bus.ready_in = 1'b0;
        vectors++;
        if (bus.valid_out !== 1'b0 || bus.count !== 5'd0) begin
            miscompares++; $display("FAIL async_after: got v=%b c=%0d expected 0/0", bus.valid_out, bus.count);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        bus.din      = '0;
        bus.valid_in = 1'b0;
        bus.flush    = 1'b0;
        bus.clr_ovf  = 1'b0;
        bus.ready_in = 1'b0;
        tick();
        tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_flush_clr();
        test_sat_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
